// File: rtl/mii_rx_deframer.sv
// mii_rx_deframer: recovers MAC frames (DA..FCS) from a 64-bit, 8-lane MII receive stream.
// Optional feature macro: MII_RX_FCS_CHECK_EN enables the CRC-32 residue check behind o_fcs_err.
module mii_rx_deframer #(
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1518,
  parameter logic [7:0]  START_CODE    = 8'hFB,
  parameter logic [7:0]  TERM_CODE     = 8'hFD,
  parameter logic [7:0]  IDLE_CODE     = 8'h07,
  parameter logic [7:0]  PREAMBLE_CODE = 8'h55,
  parameter logic [7:0]  SFD_CODE      = 8'hD5
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic [63:0] i_mii_data,
  input  logic [7:0]  i_mii_ctrl,
  output logic [63:0] o_data,
  output logic [7:0]  o_keep,
  output logic        o_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic [15:0] o_frame_len,
  output logic        o_err,
  output logic        o_len_err,
  output logic        o_fcs_err,
  output logic        o_pre_err
);

  localparam logic [15:0] MIN_LEN   = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] MAX_LEN   = 16'(MAX_FRAME_LEN);
  localparam logic [63:0] IDLE_WORD = {8{IDLE_CODE}};

  typedef enum logic {ST_IDLE, ST_DATA} state_t;

  state_t      r_state, w_state_next;

  logic [63:0] r_in_data;
  logic [7:0]  r_in_ctrl;

  logic [63:0] r_hold_data, w_hold_data_next;
  logic [7:0]  r_hold_keep, w_hold_keep_next;
  logic        r_hold_vld, w_hold_vld_next;
  logic        r_eof_pend, w_eof_pend_next;
  logic [15:0] r_pend_len, w_pend_len_next;
  logic        r_pend_fcs_bad, w_pend_fcs_bad_next;
  logic        r_sof_arm, w_sof_arm_next;
  logic [15:0] r_cnt;

  logic        w_frame_clr, w_push_full;
  logic        w_fcs_bad_held, w_fcs_bad_part;

  logic [63:0] r_out_data, w_out_data;
  logic [7:0]  r_out_keep, w_out_keep;
  logic        r_out_valid, w_out_valid;
  logic        r_out_sof, w_out_sof;
  logic        r_out_eof, w_out_eof;
  logic [15:0] r_out_len, w_out_len;
  logic        r_out_err, w_out_err;
  logic        r_out_len_err, w_out_len_err;
  logic        r_out_fcs_err, w_out_fcs_err;
  logic        r_pre_err, w_pre_err_next;

  logic        w_start_lane0, w_start_ok, w_term;
  logic [2:0]  w_term_lane;
  logic [7:0]  w_term_keep;
  logic [63:0] w_term_bits;

  function automatic logic [2:0] f_first_ctrl(input logic [7:0] c);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (c[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [15:0] f_sat_add(input logic [15:0] a, input logic [3:0] n);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic f_len_bad(input logic [15:0] len);
    return (len < MIN_LEN) || (len > MAX_LEN);
  endfunction

  // Input capture stage: gives the two-edge data latency together with the hold register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_data <= '0;
      r_in_ctrl <= '0;
    end else begin
      r_in_data <= i_mii_data;
      r_in_ctrl <= i_mii_ctrl;
    end
  end

  // The lowest set ctrl bit is the only candidate TERM position; lanes below it are data.
  always_comb begin
    w_start_lane0 = r_in_ctrl[0] && (r_in_data[7:0] == START_CODE);
    w_start_ok    = w_start_lane0 && (r_in_ctrl == 8'h01) &&
                    (r_in_data[55:8] == {6{PREAMBLE_CODE}}) &&
                    (r_in_data[63:56] == SFD_CODE);
    w_term_lane   = f_first_ctrl(r_in_ctrl);
    w_term        = (r_in_ctrl != 8'h00) &&
                    (r_in_data[{w_term_lane, 3'b000} +: 8] == TERM_CODE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_term_mask
      assign w_term_keep[gi]           = (3'(gi) < w_term_lane);
      assign w_term_bits[8*gi +: 8]    = {8{w_term_keep[gi]}};
    end
  endgenerate

`ifdef MII_RX_FCS_CHECK_EN
  localparam logic        FCS_EN      = 1'b1;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  logic [31:0] r_crc;
  logic [31:0] w_crc_full, w_crc_part;

  function automatic logic [31:0] f_crc(input logic [31:0] crc_in, input logic [63:0] d,
                                        input logic [7:0] keep);
    logic [31:0] c;
    c = crc_in;
    for (int b = 0; b < 8; b++) begin
      if (keep[b]) begin
        c = c ^ {24'd0, d[8*b +: 8]};
        for (int j = 0; j < 8; j++) begin
          c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  always_comb begin
    w_crc_full     = f_crc(r_crc, r_in_data, 8'hFF);
    w_crc_part     = f_crc(r_crc, r_in_data, w_term_keep);
    w_fcs_bad_held = (r_crc != CRC_RESIDUE);
    w_fcs_bad_part = (w_crc_part != CRC_RESIDUE);
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_crc <= '1;
    end else if (w_frame_clr) begin
      r_crc <= '1;
    end else if (w_push_full) begin
      r_crc <= w_crc_full;
    end
  end
`else
  localparam logic FCS_EN = 1'b0;

  assign w_fcs_bad_held = 1'b0;
  assign w_fcs_bad_part = 1'b0;
`endif

  // Byte counter covers every word that has entered the hold register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_frame_clr) begin
      r_cnt <= '0;
    end else if (w_push_full) begin
      r_cnt <= f_sat_add(r_cnt, 4'd8);
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    w_hold_data_next    = r_hold_data;
    w_hold_keep_next    = r_hold_keep;
    w_hold_vld_next     = r_hold_vld;
    w_eof_pend_next     = 1'b0;
    w_pend_len_next     = r_pend_len;
    w_pend_fcs_bad_next = r_pend_fcs_bad;
    w_sof_arm_next      = r_sof_arm;
    w_frame_clr         = 1'b0;
    w_push_full         = 1'b0;
    w_pre_err_next      = 1'b0;
    w_out_valid         = 1'b0;
    w_out_data          = r_hold_data;
    w_out_keep          = r_hold_keep;
    w_out_sof           = 1'b0;
    w_out_eof           = 1'b0;
    w_out_len           = 16'd0;
    w_out_err           = 1'b0;
    w_out_len_err       = 1'b0;
    w_out_fcs_err       = 1'b0;

    // A partial TERM word drains one cycle after it was captured; the FSM is already IDLE.
    if (r_eof_pend) begin
      w_out_valid     = 1'b1;
      w_out_sof       = r_sof_arm;
      w_out_eof       = 1'b1;
      w_out_len       = r_pend_len;
      w_out_len_err   = f_len_bad(r_pend_len);
      w_out_fcs_err   = r_pend_fcs_bad;
      w_hold_vld_next = 1'b0;
      w_sof_arm_next  = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_start_lane0) begin
          if (w_start_ok) begin
            w_state_next   = ST_DATA;
            w_frame_clr    = 1'b1;
            w_sof_arm_next = 1'b1;
          end else begin
            w_pre_err_next = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (r_in_ctrl == 8'h00) begin
          w_push_full      = 1'b1;
          w_hold_data_next = r_in_data;
          w_hold_keep_next = 8'hFF;
          w_hold_vld_next  = 1'b1;
          if (r_hold_vld) begin
            w_out_valid    = 1'b1;
            w_out_sof      = r_sof_arm;
            w_sof_arm_next = 1'b0;
          end
        end else if (w_term && (w_term_lane == 3'd0)) begin
          w_out_valid     = 1'b1;
          w_out_sof       = r_sof_arm;
          w_out_eof       = 1'b1;
          w_out_len       = r_cnt;
          w_out_len_err   = f_len_bad(r_cnt);
          w_out_fcs_err   = w_fcs_bad_held;
          w_sof_arm_next  = 1'b0;
          w_hold_vld_next = 1'b0;
          w_state_next    = ST_IDLE;
          if (!r_hold_vld) begin
            w_out_data = IDLE_WORD;
            w_out_keep = 8'h00;
          end
        end else if (w_term) begin
          if (r_hold_vld) begin
            w_out_valid    = 1'b1;
            w_out_sof      = r_sof_arm;
            w_sof_arm_next = 1'b0;
          end
          // Lanes from the TERM upward are replaced with IDLE so no control byte leaks out.
          w_hold_data_next    = (r_in_data & w_term_bits) | (IDLE_WORD & ~w_term_bits);
          w_hold_keep_next    = w_term_keep;
          w_hold_vld_next     = 1'b1;
          w_eof_pend_next     = 1'b1;
          w_pend_len_next     = f_sat_add(r_cnt, {1'b0, w_term_lane});
          w_pend_fcs_bad_next = w_fcs_bad_part;
          w_state_next        = ST_IDLE;
        end else begin
          w_out_valid     = 1'b1;
          w_out_sof       = r_sof_arm;
          w_out_eof       = 1'b1;
          w_out_err       = 1'b1;
          w_out_len       = r_cnt;
          w_out_len_err   = 1'b1;
          w_out_fcs_err   = FCS_EN;
          w_sof_arm_next  = 1'b0;
          w_hold_vld_next = 1'b0;
          w_state_next    = ST_IDLE;
          if (!r_hold_vld) begin
            w_out_data = IDLE_WORD;
            w_out_keep = 8'h00;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold_data    <= '0;
      r_hold_keep    <= '0;
      r_hold_vld     <= 1'b0;
      r_eof_pend     <= 1'b0;
      r_pend_len     <= '0;
      r_pend_fcs_bad <= 1'b0;
      r_sof_arm      <= 1'b0;
      r_out_data     <= '0;
      r_out_keep     <= '0;
      r_out_valid    <= 1'b0;
      r_out_sof      <= 1'b0;
      r_out_eof      <= 1'b0;
      r_out_len      <= '0;
      r_out_err      <= 1'b0;
      r_out_len_err  <= 1'b0;
      r_out_fcs_err  <= 1'b0;
      r_pre_err      <= 1'b0;
    end else begin
      r_hold_data    <= w_hold_data_next;
      r_hold_keep    <= w_hold_keep_next;
      r_hold_vld     <= w_hold_vld_next;
      r_eof_pend     <= w_eof_pend_next;
      r_pend_len     <= w_pend_len_next;
      r_pend_fcs_bad <= w_pend_fcs_bad_next;
      r_sof_arm      <= w_sof_arm_next;
      r_out_data     <= w_out_data;
      r_out_keep     <= w_out_keep;
      r_out_valid    <= w_out_valid;
      r_out_sof      <= w_out_sof;
      r_out_eof      <= w_out_eof;
      r_out_len      <= w_out_len;
      r_out_err      <= w_out_err;
      r_out_len_err  <= w_out_len_err;
      r_out_fcs_err  <= w_out_fcs_err;
      r_pre_err      <= w_pre_err_next;
    end
  end

  assign o_data      = r_out_data;
  assign o_keep      = r_out_keep;
  assign o_valid     = r_out_valid;
  assign o_sof       = r_out_sof;
  assign o_eof       = r_out_eof;
  assign o_frame_len = r_out_len;
  assign o_err       = r_out_err;
  assign o_len_err   = r_out_len_err;
  assign o_fcs_err   = r_out_fcs_err;
  assign o_pre_err   = r_pre_err;

endmodule
